// File: rtl/vga_avn_pkg.sv
// Shared arbitration constants and the rotating priority pick used by the
// N-port vram multiplexer.
package vga_avn_pkg;

    typedef enum int unsigned {
        ARB_FIXED = 0,
        ARB_RR    = 1
    } arb_mode_e;

    localparam int unsigned MAX_PORT = 8;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    // First set request at or after ptr, wrapping modulo nport. Walking the
    // offsets from ptr is the rotate / priority-encode / unrotate in one pass.
    function automatic pick_t pkg_rr_pick(input logic [MAX_PORT-1:0] req,
                                          input logic [2:0]          ptr,
                                          input int unsigned         nport);
        pick_t       p;
        int unsigned idx;
        p = '0;
        for (int unsigned i = 0; i < MAX_PORT; i++) begin
            idx = int'(ptr) + i;
            if (idx >= nport) idx = idx - nport;
            if (i < nport && !p.found && req[idx[2:0]]) begin
                p.found = 1'b1;
                p.idx   = idx[2:0];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/vga_avn_tag_fifo.sv
// In-order return tag FIFO: records which port issued each accepted read so
// the matching readdatavalid can be steered back to it.
module vga_avn_tag_fifo
    import vga_avn_pkg::*;
#(
    parameter int W     = 2,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign dout    = mem[rd_ptr];

    // Tag storage; contents need no reset since empty gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointer and occupancy tracking; push+pop together leaves cnt unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/vga_avn_mux_n.sv
// N-port Avalon-MM arbiter/multiplexer sharing one vram port. Command and
// read-data paths are combinational; only arbitration state is registered.
module vga_avn_mux_n
    import vga_avn_pkg::*;
#(
    parameter int NPORT        = 4,
    parameter int AVN_AW       = 18,
    parameter int AVN_DW       = 16,
    parameter int PENDING_READ = 16,
    parameter int ARB_MODE     = 1
) (
    input  logic                            sys_clk,
    input  logic                            sys_rst_n,
    input  logic [NPORT-1:0]                port_avn_read,
    input  logic [NPORT-1:0]                port_avn_write,
    input  logic [NPORT*AVN_AW-1:0]         port_avn_address,
    input  logic [NPORT*AVN_DW-1:0]         port_avn_writedata,
    input  logic [NPORT*(AVN_DW/8)-1:0]     port_avn_byteenable,
    output logic [AVN_DW-1:0]               port_avn_readdata,
    output logic [NPORT-1:0]                port_avn_readdatavalid,
    output logic [NPORT-1:0]                port_avn_waitrequest,
    output logic                            out_avn_read,
    output logic                            out_avn_write,
    output logic [AVN_AW-1:0]               out_avn_address,
    output logic [AVN_DW-1:0]               out_avn_writedata,
    output logic [AVN_DW/8-1:0]             out_avn_byteenable,
    input  logic [AVN_DW-1:0]               out_avn_readdata,
    input  logic                            out_avn_readdatavalid,
    input  logic                            out_avn_waitrequest,
    output logic [$clog2(PENDING_READ):0]   pending_cnt,
    output logic                            err_rdv
);

    localparam int TW = $clog2(NPORT);
    localparam int BW = AVN_DW / 8;

    logic [NPORT-1:0]    elig;
    logic [MAX_PORT-1:0] elig_ext;
    logic [2:0]          ptr_ext;
    pick_t               pick;
    logic                lock_vld;
    logic [TW-1:0]       lock_idx;
    logic [TW-1:0]       rr_ptr;
    logic                gnt_vld;
    logic [TW-1:0]       gnt_idx;
    logic                sel_rd;
    logic                sel_wr;
    logic                accept;
    logic                push;
    logic                pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [TW-1:0]       fifo_head;

    // Eligibility and grant selection; a held lock overrides arbitration.
    always_comb begin
        elig     = '0;
        elig_ext = '0;
        for (int unsigned i = 0; i < NPORT; i++) begin
            elig[i] = port_avn_write[i] | (port_avn_read[i] & ~fifo_full);
        end
        elig_ext[NPORT-1:0] = elig;
        ptr_ext  = (ARB_MODE == int'(ARB_RR)) ? 3'(rr_ptr) : '0;
        pick     = pkg_rr_pick(elig_ext, ptr_ext, NPORT);
        if (lock_vld) begin
            gnt_vld = 1'b1;
            gnt_idx = lock_idx;
        end else begin
            gnt_vld = pick.found;
            gnt_idx = TW'(pick.idx);
        end
    end

    // Downstream command mux. Write wins over read on the same port; a locked
    // read is held off while the tag FIFO is full so no tag is ever dropped.
    always_comb begin
        sel_wr             = port_avn_write[gnt_idx];
        sel_rd             = port_avn_read[gnt_idx] & ~port_avn_write[gnt_idx] & ~fifo_full;
        out_avn_write      = sys_rst_n & gnt_vld & sel_wr;
        out_avn_read       = sys_rst_n & gnt_vld & sel_rd;
        out_avn_address    = port_avn_address[int'(gnt_idx)*AVN_AW +: AVN_AW];
        out_avn_writedata  = port_avn_writedata[int'(gnt_idx)*AVN_DW +: AVN_DW];
        out_avn_byteenable = port_avn_byteenable[int'(gnt_idx)*BW +: BW];
        accept             = (out_avn_read | out_avn_write) & ~out_avn_waitrequest;
        push               = accept & out_avn_read;
        pop                = out_avn_readdatavalid & ~fifo_empty;
    end

    // Per-port stall and return steering; data is broadcast.
    always_comb begin
        port_avn_waitrequest   = '1;
        port_avn_readdatavalid = '0;
        if (out_avn_read | out_avn_write) port_avn_waitrequest[gnt_idx] = out_avn_waitrequest;
        if (pop) port_avn_readdatavalid[fifo_head] = 1'b1;
        port_avn_readdata = out_avn_readdata;
    end

    // Lock across waitrequest, round-robin pointer and sticky return error.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            lock_vld <= 1'b0;
            lock_idx <= '0;
            rr_ptr   <= '0;
            err_rdv  <= 1'b0;
        end else begin
            if (accept) begin
                lock_vld <= 1'b0;
            end else if (out_avn_read | out_avn_write) begin
                lock_vld <= 1'b1;
                lock_idx <= gnt_idx;
            end
            if (accept && ARB_MODE == int'(ARB_RR)) begin
                rr_ptr <= (gnt_idx == TW'(NPORT-1)) ? '0 : gnt_idx + 1'b1;
            end
            if (out_avn_readdatavalid && fifo_empty) err_rdv <= 1'b1;
        end
    end

    vga_avn_tag_fifo #(
        .W     (TW),
        .DEPTH (PENDING_READ)
    ) u_tag_fifo (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .push  (push),
        .din   (gnt_idx),
        .pop   (pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (pending_cnt)
    );

endmodule
